serial_word_rx: RTL and testbench

// Serial-to-parallel receiver: the far end of the universal shift register's serial output.

---
 rtl/serial_word_rx.sv | 101 ++++++++++
 tb/tb_serial_word_rx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_rx.sv
// Serial-to-parallel word receiver with a one-deep valid/ready output buffer.
// A start strobe opens a frame. W qualified bits are shifted in LSB- or
// MSB-first, and the finished word is handed to the parallel consumer.
module serial_word_rx #(
  parameter int unsigned W = 8
) (
  input  logic         c,
  input  logic         nrst,
  input  logic         si,
  input  logic         sv,
  input  logic         start,
  input  logic         dir,
  output logic [W-1:0] q,
  output logic         qv,
  input  logic         qr,
  output logic         busy,
  output logic         ovf,
  output logic         abrt
);

  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t        state;
  logic [W-1:0]  sh;
  logic [CW-1:0] cnt;
  logic          dir_r;

  logic [W-1:0]  sh_next;
  logic          last_bit;
  logic          buf_free;

  // Shift register contents after taking si in the latched bit order.
  always_comb begin
    sh_next = sh;
    if (dir_r) sh_next = {sh[W-2:0], si};
    else       sh_next = {si, sh[W-1:1]};
  end

  assign last_bit = (cnt == CW'(W - 1));
  assign buf_free = !qv || qr;
  assign busy     = (state == RECV);

  // Frame FSM, shift/count datapath, output buffer and event pulses.
  always_ff @(posedge c or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
      dir_r <= 1'b0;
      q     <= '0;
      qv    <= 1'b0;
      ovf   <= 1'b0;
      abrt  <= 1'b0;
    end else begin
      ovf  <= 1'b0;
      abrt <= 1'b0;
      if (qv && qr) qv <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          sh  <= '0;
          if (start) begin
            state <= RECV;
            dir_r <= dir;
          end
        end
        RECV: begin
          if (start) begin
            // Restart wins over a bit arriving on the same edge.
            cnt   <= '0;
            sh    <= '0;
            dir_r <= dir;
            abrt  <= 1'b1;
          end else if (sv) begin
            if (last_bit) begin
              state <= IDLE;
              cnt   <= '0;
              sh    <= '0;
              if (buf_free) begin
                q  <= sh_next;
                qv <= 1'b1;
              end else begin
                ovf <= 1'b1;
              end
            end else begin
              sh  <= sh_next;
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_rx.sv
// Self-checking bench for serial_word_rx: directed frames with literal
// expectations, then randomized traffic compared against a queue-based model.
module tb_serial_word_rx;

  localparam int unsigned W = 8;

  logic         c;
  logic         nrst;
  logic         si;
  logic         sv;
  logic         start;
  logic         dir;
  logic [W-1:0] q;
  logic         qv;
  logic         qr;
  logic         busy;
  logic         ovf;
  logic         abrt;

  int checks = 0;
  int errors = 0;

  serial_word_rx #(.W(W)) dut (
    .c(c), .nrst(nrst), .si(si), .sv(sv), .start(start), .dir(dir),
    .q(q), .qv(qv), .qr(qr), .busy(busy), .ovf(ovf), .abrt(abrt)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: collect frame bits in a queue, build the word arithmetically.
  bit           m_recv = 1'b0;
  bit           m_dir  = 1'b0;
  bit           m_bits[$];
  logic [W-1:0] m_q    = '0;
  bit           m_qv   = 1'b0;
  bit           m_ovf  = 1'b0;
  bit           m_abrt = 1'b0;

  function automatic logic [W-1:0] assemble(input bit d);
    int unsigned w;
    w = 0;
    for (int i = 0; i < int'(W); i++)
      if (m_bits[i]) w = w + (32'd1 << (d ? (int'(W) - 1 - i) : i));
    return W'(w);
  endfunction

  always @(posedge c or negedge nrst) begin : mdl
    bit free;
    if (!nrst) begin
      m_recv = 1'b0; m_dir = 1'b0; m_bits.delete();
      m_q = '0; m_qv = 1'b0; m_ovf = 1'b0; m_abrt = 1'b0;
    end else begin
      free   = !m_qv || qr;
      m_ovf  = 1'b0;
      m_abrt = 1'b0;
      if (m_qv && qr) m_qv = 1'b0;
      if (!m_recv) begin
        if (start) begin
          m_recv = 1'b1; m_dir = dir; m_bits.delete();
        end
      end else if (start) begin
        m_abrt = 1'b1; m_dir = dir; m_bits.delete();
      end else if (sv) begin
        m_bits.push_back(si);
        if (m_bits.size() == W) begin
          m_recv = 1'b0;
          if (free) begin
            m_q  = assemble(m_dir);
            m_qv = 1'b1;
          end else begin
            m_ovf = 1'b1;
          end
          m_bits.delete();
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge c) begin
    if (nrst === 1'b1) begin
      chk("q",    32'(q),    32'(m_q));
      chk("qv",   32'(qv),   32'(m_qv));
      chk("busy", 32'(busy), 32'(m_recv));
      chk("ovf",  32'(ovf),  32'(m_ovf));
      chk("abrt", 32'(abrt), 32'(m_abrt));
    end
  end

  task automatic drive(input bit st, input bit d, input bit s, input bit v, input bit r);
    @(negedge c);
    start = st; dir = d; si = s; sv = v; qr = r;
  endtask

  // seq[i] is the i-th bit placed on the line; gap idle cycles precede each bit.
  task automatic send_word(input bit d, input logic [W-1:0] seq, input int gap,
                           input bit r, input bit rl);
    drive(1'b1, d, 1'b0, 1'b0, r);
    for (int i = 0; i < int'(W); i++) begin
      for (int g = 0; g < gap; g++) drive(1'b0, d, 1'b0, 1'b0, r);
      drive(1'b0, d, seq[i], 1'b1, (i == int'(W) - 1) ? rl : r);
    end
    chk("busy_in_frame", 32'(busy), 32'd1);
  endtask

  initial begin
    nrst = 1'b0; start = 1'b0; dir = 1'b0; si = 1'b0; sv = 1'b0; qr = 1'b0;
    #12;
    chk("rst_q",    32'(q),    32'd0);
    chk("rst_qv",   32'(qv),   32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge c); nrst = 1'b1;

    // LSB first
    send_word(1'b0, 8'h1B, 0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("lsb_q", 32'(q), 32'h1B);
    chk("lsb_qv", 32'(qv), 32'd1);
    chk("lsb_busy_after", 32'(busy), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lsb_drain", 32'(qv), 32'd0);
    chk("lsb_q_hold", 32'(q), 32'h1B);

    // MSB first
    send_word(1'b1, 8'h1B, 0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("msb_q", 32'(q), 32'hD8);
    chk("msb_qv", 32'(qv), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // sv gaps
    send_word(1'b0, 8'h1B, 2, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("gap_q", 32'(q), 32'h1B);
    chk("gap_qv", 32'(qv), 32'd1);

    // Backpressure: second word dropped
    send_word(1'b0, 8'h55, 0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_ovf", 32'(ovf), 32'd1);
    chk("bp_q", 32'(q), 32'h1B);
    chk("bp_qv", 32'(qv), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_ovf_pulse", 32'(ovf), 32'd0);

    // Back-to-back: consumer accepts on the completing edge
    send_word(1'b0, 8'h96, 0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b_q", 32'(q), 32'h96);
    chk("b2b_qv", 32'(qv), 32'd1);
    chk("b2b_ovf", 32'(ovf), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b_drain", 32'(qv), 32'd0);

    // Abort after 4 bits, then a clean word
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    begin
      logic [W-1:0] ab;
      ab = 8'hA5;
      for (int i = 0; i < int'(W); i++) begin
        drive(1'b0, 1'b0, ab[i], 1'b1, 1'b0);
        if (i == 0) chk("abrt_pulse", 32'(abrt), 32'd1);
        if (i == 1) chk("abrt_one_cycle", 32'(abrt), 32'd0);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("abrt_clean_q", 32'(q), 32'hA5);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Start on the same edge as the W-th bit
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < int'(W) - 1; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("collide_abrt", 32'(abrt), 32'd1);
    chk("collide_qv", 32'(qv), 32'd0);
    chk("collide_busy", 32'(busy), 32'd1);

    // Reset mid-frame with a buffered word
    send_word(1'b0, 8'h3C, 0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("pre_rst_q", 32'(q), 32'h3C);
    #2 nrst = 1'b0;
    #1;
    chk("mid_rst_q", 32'(q), 32'd0);
    chk("mid_rst_qv", 32'(qv), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pulses", 32'({ovf, abrt}), 32'd0);
    @(negedge c); nrst = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      @(negedge c);
      nrst  = ($urandom_range(0, 299) != 0);
      start = ($urandom_range(0, 19) == 0);
      dir   = 1'($urandom_range(0, 1));
      si    = 1'($urandom_range(0, 1));
      sv    = ($urandom_range(0, 3) != 0);
      qr    = 1'($urandom_range(0, 1));
    end
    @(negedge c);
    nrst = 1'b1; start = 1'b0; sv = 1'b0;
    repeat (2) @(negedge c);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
